mb_io_bus_ctrl: RTL
===================

MB_IO_BUS_CTRL -- requirements
Module: mb_io_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning WAIT cycles without slave ready before error completion (legal range 2..255).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, meaning read data returned on timeout or decode error.
REQ-003 clk  input  1  the one system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe  input  1 each  MCS IO bus request strobes.
REQ-006 IO_Address  input  32  byte address; IO_Byte_Enable  input  4; IO_Write_Data  input  32.
REQ-007 IO_Read_Data  output  32  read return data; IO_Ready  output  1  one-cycle completion pulse.
REQ-008 s_sel  output  4  one-hot slave select; s_rd_stb, s_wr_stb  output  1 each  one-cycle slave strobes.
REQ-009 s_addr  output  6  word offset; s_be  output  4; s_wdata  output  32.
REQ-010 s_rdata  input  128  four 32-bit read buses; slave k occupies bits [32k+31:32k].
REQ-011 s_ready  input  4  per-slave completion.
REQ-012 err_count  output  8  saturating count of error completions; err_last  output  1  last completion was an error.

Function
REQ-013 The block SHALL accept a request in IDLE when IO_Addr_Strobe=1 and exactly one of IO_Read_Strobe or IO_Write_Strobe=1; any other strobe combination SHALL be ignored.
REQ-014 On acceptance the block SHALL latch the address, byte enables, write data and direction.
REQ-015 Decode rules:
- IO_Address[31:30]==2'b11 is a valid access.
- Slave index = IO_Address[9:8].
- s_addr = IO_Address[7:2].
- IO_Address[29:10] is ignored.
REQ-016 States SHALL be IDLE, WAIT and RESP.
REQ-017 IDLE to WAIT: valid accepted request; next cycle s_sel is one-hot(index) and s_rd_stb or s_wr_stb =1 for exactly that cycle.
REQ-018 IDLE to RESP: accepted request with an invalid region; no slave strobe is issued.
REQ-019 WAIT: s_sel, s_addr, s_be and s_wdata SHALL hold; s_ready of the selected slave only is sampled; unselected s_ready bits are ignored.
REQ-020 WAIT to IDLE on selected s_ready:
- IO_Ready=1 the following cycle.
- IO_Read_Data = selected s_rdata slice registered on the ready cycle for reads, 0 for writes.
- s_sel cleared; err_last=0.
REQ-021 Timeout counter:
- Counts from 1 on WAIT entry.
- Reaching TIMEOUT_CYCLES without ready moves to RESP.
- Ready on the terminal count cycle wins over timeout.
REQ-022 RESP: drives one-cycle IO_Ready with IO_Read_Data=ERR_DATA (reads) or 0 (writes), sets err_last=1, increments err_count saturating at 255, clears s_sel, returns to IDLE.
REQ-023 Bus strobes arriving outside IDLE SHALL be ignored.
REQ-024 Latency: strobe at cycle N gives slave strobe at N+1; slave ready at cycle M gives IO_Ready at M+1; decode error gives IO_Ready at N+1.
REQ-025 IO_Read_Data SHALL be 0 whenever IO_Ready=0.

Reset
REQ-026 With reset=0 at a clock edge, the state SHALL be IDLE and all outputs SHALL be 0, including err_count and err_last.
REQ-027 Reset mid-transaction SHALL abort it with no IO_Ready pulse and the timeout counter cleared.

Structure
REQ-028 Package mb_io_pkg SHALL hold:
- the state enum;
- REGION_TAG=2'b11;
- the default ERR_DATA and TIMEOUT_CYCLES constants;
- slave-count constant 4.
REQ-029 The timeout counter SHALL be a sub-module named mb_io_watchdog, with inputs start, clear and terminal count, and output expired.

Verification
REQ-030 Read of 0xC000_0204, slave 2 ready after 3 cycles with s_rdata[95:64]=0x1234_5678 -> s_sel=4'b0100, s_addr=1, one s_rd_stb, IO_Ready one cycle later with data 0x1234_5678.
REQ-031 Write 0xA5A5_0001 to 0xC000_0008 with BE=4'b0011, slave 0 ready immediately -> s_wdata and s_be match, IO_Ready at N+2, IO_Read_Data=0.
REQ-032 Read of 0xC000_0300 with slave 3 never ready -> IO_Ready after TIMEOUT_CYCLES, data 0xDEAD_BEEF, err_count=1, err_last=1.
REQ-033 Read of 0x4000_0000 -> no s_sel or slave strobe, IO_Ready at N+1 with 0xDEAD_BEEF; 300 such errors -> err_count=255.
REQ-034 Reset asserted in WAIT -> no IO_Ready pulse, all outputs 0; next request completes normally.
REQ-035 Unselected s_ready asserted during WAIT -> ignored; ready on the terminal-count cycle -> normal data, err_count unchanged.

Source files
------------

// File: rtl/mb_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mb_io_pkg
// Description : Shared types and constants for the MCS IO bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mb_io_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Address bits [31:30] must carry this tag for a slave access
  localparam logic [1:0]  REGION_TAG         = 2'b11;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;
  localparam int          DEF_TIMEOUT_CYCLES = 64;
  localparam int          NUM_SLAVES         = 4;

  // Increment that sticks at the top of the 8-bit range
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mb_io_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mb_io_watchdog
// Description : Wait-state counter. Loads 1 on start, counts up to the
//               terminal count and flags expiry while parked there.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_io_watchdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] term_count,
  output logic       expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear dominates, start loads 1, otherwise climb to the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (start) begin
      cnt_d = 8'd1;
    end else if ((cnt_q != 8'd0) && (cnt_q != term_count)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q != 8'd0) && (cnt_q == term_count);

endmodule
`default_nettype wire

// File: rtl/mb_io_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mb_io_bus_ctrl
// Description : Bridges the MicroBlaze MCS IO bus onto four simple slaves
//               with one-hot select, timeout and decode-error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_io_bus_ctrl
  import mb_io_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         IO_Addr_Strobe,
  input  logic         IO_Read_Strobe,
  input  logic         IO_Write_Strobe,
  input  logic [31:0]  IO_Address,
  input  logic [3:0]   IO_Byte_Enable,
  input  logic [31:0]  IO_Write_Data,
  output logic [31:0]  IO_Read_Data,
  output logic         IO_Ready,
  output logic [3:0]   s_sel,
  output logic         s_rd_stb,
  output logic         s_wr_stb,
  output logic [5:0]   s_addr,
  output logic [3:0]   s_be,
  output logic [31:0]  s_wdata,
  input  logic [127:0] s_rdata,
  input  logic [3:0]   s_ready,
  output logic [7:0]   err_count,
  output logic         err_last
);

  localparam logic [7:0] TERM_COUNT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        dir_q, dir_d;             // 1 = read
  logic [3:0]  s_sel_q, s_sel_d;
  logic [5:0]  s_addr_q, s_addr_d;
  logic [3:0]  s_be_q, s_be_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        s_rd_stb_q, s_rd_stb_d;
  logic        s_wr_stb_q, s_wr_stb_d;
  logic        io_ready_q, io_ready_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        err_last_q, err_last_d;

  logic        w_accept;
  logic        w_region_ok;
  logic        w_sel_ready;
  logic [31:0] w_sel_rdata;
  logic        w_done_ok;
  logic        w_done_err;
  logic        w_wd_start;
  logic        w_wd_clear;
  logic        w_wd_expired;
  logic        w_unused_addr;

  // Exactly one direction strobe alongside the address strobe forms a request
  assign w_accept      = IO_Addr_Strobe && (IO_Read_Strobe ^ IO_Write_Strobe);
  assign w_region_ok   = (IO_Address[31:30] == REGION_TAG);
  assign w_sel_ready   = |(s_ready & s_sel_q);
  assign w_unused_addr = ^{IO_Address[29:10], IO_Address[1:0]};

  // Read data mux driven by the held one-hot select
  always_comb begin
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_sel_q[k]) begin
        w_sel_rdata = s_rdata[32*k +: 32];
      end
    end
  end

  mb_io_watchdog u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .start      (w_wd_start),
    .clear      (w_wd_clear),
    .term_count (TERM_COUNT),
    .expired    (w_wd_expired)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    s_sel_d     = s_sel_q;
    s_addr_d    = s_addr_q;
    s_be_d      = s_be_q;
    s_wdata_d   = s_wdata_q;
    s_rd_stb_d  = 1'b0;
    s_wr_stb_d  = 1'b0;
    io_ready_d  = 1'b0;
    io_rdata_d  = '0;
    err_count_d = err_count_q;
    err_last_d  = err_last_q;
    w_wd_start  = 1'b0;
    w_wd_clear  = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          dir_d = IO_Read_Strobe;
          if (w_region_ok) begin
            state_d    = ST_WAIT;
            s_sel_d    = 4'b0001 << IO_Address[9:8];
            s_addr_d   = IO_Address[7:2];
            s_be_d     = IO_Byte_Enable;
            s_wdata_d  = IO_Write_Data;
            s_rd_stb_d = IO_Read_Strobe;
            s_wr_stb_d = IO_Write_Strobe;
            w_wd_start = 1'b1;
          end else begin
            state_d    = ST_RESP;
            w_done_err = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Selected ready is checked first so it wins on the terminal-count cycle
        if (w_sel_ready) begin
          state_d   = ST_IDLE;
          w_done_ok = 1'b1;
        end else if (w_wd_expired) begin
          state_d    = ST_RESP;
          w_done_err = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_done_ok) begin
      io_ready_d = 1'b1;
      io_rdata_d = dir_d ? w_sel_rdata : 32'd0;
      err_last_d = 1'b0;
    end

    // The error response is loaded on entry to RESP so IO_Ready shows during RESP
    if (w_done_err) begin
      io_ready_d  = 1'b1;
      io_rdata_d  = dir_d ? ERR_DATA : 32'd0;
      err_last_d  = 1'b1;
      err_count_d = sat_inc8(err_count_q);
    end

    if ((state_q == ST_WAIT) && (w_done_ok || w_done_err)) begin
      w_wd_clear = 1'b1;
      s_sel_d    = '0;
      s_addr_d   = '0;
      s_be_d     = '0;
      s_wdata_d  = '0;
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      s_sel_q     <= '0;
      s_addr_q    <= '0;
      s_be_q      <= '0;
      s_wdata_q   <= '0;
      s_rd_stb_q  <= 1'b0;
      s_wr_stb_q  <= 1'b0;
      io_ready_q  <= 1'b0;
      io_rdata_q  <= '0;
      err_count_q <= '0;
      err_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      s_sel_q     <= s_sel_d;
      s_addr_q    <= s_addr_d;
      s_be_q      <= s_be_d;
      s_wdata_q   <= s_wdata_d;
      s_rd_stb_q  <= s_rd_stb_d;
      s_wr_stb_q  <= s_wr_stb_d;
      io_ready_q  <= io_ready_d;
      io_rdata_q  <= io_rdata_d;
      err_count_q <= err_count_d;
      err_last_q  <= err_last_d;
    end
  end

  assign IO_Ready     = io_ready_q;
  assign IO_Read_Data = io_rdata_q;
  assign s_sel        = s_sel_q;
  assign s_rd_stb     = s_rd_stb_q;
  assign s_wr_stb     = s_wr_stb_q;
  assign s_addr       = s_addr_q;
  assign s_be         = s_be_q;
  assign s_wdata      = s_wdata_q;
  assign err_count    = err_count_q;
  assign err_last     = err_last_q;

endmodule
`default_nettype wire
